// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared FSM state, stall cause and register-zero constant
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {ST_RUN, ST_DIV, ST_DONE} state_t;
    typedef enum logic [2:0] {C_NONE, C_MEM_WAIT, C_BRANCH, C_LOAD_USE, C_DIV} cause_t;
    localparam logic [4:0] REG0 = 5'd0;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs and stall/flush controls; PIPE_HAZ_PERF_EN adds perf counters
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic id_uses_rt, ex_mem_read, ex_branch_taken, ex_div, dmem_req, dmem_ack;
    logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic if_id_flush, id_ex_flush, mem_wb_flush;
    logic div_busy, div_done;
`ifdef PIPE_HAZ_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif
    modport master (
        input id_rs, id_rt, ex_rt, id_uses_rt, ex_mem_read, ex_branch_taken, ex_div, dmem_req, dmem_ack,
`ifdef PIPE_HAZ_PERF_EN
        output perf_stall_cnt, perf_flush_cnt,
`endif
        output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, mem_wb_flush, div_busy, div_done
    );
    modport slave (
        output id_rs, id_rt, ex_rt, id_uses_rt, ex_mem_read, ex_branch_taken, ex_div, dmem_req, dmem_ack,
`ifdef PIPE_HAZ_PERF_EN
        input perf_stall_cnt, perf_flush_cnt,
`endif
        input pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, mem_wb_flush, div_busy, div_done
    );
endinterface

// File: rtl/pipe_hazard_ctrl_detect.sv
// pipe_hazard_detect: load-use compare between the load in EX and the sources of the ID instruction
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       load_use
);
    assign load_use = ex_mem_read && ex_rt != REG0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the 5-stage pipeline; PIPE_HAZ_PERF_EN adds perf counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input logic clk,
    input logic rst,
    pipe_hazard_ctrl_if.master bus
);
    state_t state, state_nx;
    cause_t cause;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic mem_wait, load_use, hold;
    assign mem_wait = bus.dmem_req && !bus.dmem_ack;
    pipe_hazard_detect u_detect (
        .ex_mem_read (bus.ex_mem_read),
        .ex_rt       (bus.ex_rt),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rt  (bus.id_uses_rt),
        .load_use    (load_use)
    );
    // pick the single winning hazard cause for this cycle, highest priority first
    always_comb begin
        cause = mem_wait ? C_MEM_WAIT :
                state == ST_DIV ? C_DIV :
                state != ST_RUN ? C_NONE :
                bus.ex_branch_taken ? C_BRANCH :
                load_use ? C_LOAD_USE :
                bus.ex_div ? C_DIV : C_NONE;
    end
    // next state and divide counter; a memory wait freezes both
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (!mem_wait) begin
            case (state)
                ST_RUN: if (cause == C_DIV) begin
                    state_nx = ST_DIV;
                    cnt_nx   = CNT_W'(DIV_CYCLES - 2);
                end
                ST_DIV: if (cnt == '0) state_nx = ST_DONE;
                        else cnt_nx = cnt - 1'b1;
                default: state_nx = ST_RUN;
            endcase
        end
    end
    // FSM state and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    assign hold             = rst && (cause == C_MEM_WAIT || cause == C_DIV);
    assign bus.pc_stall     = hold || (rst && cause == C_LOAD_USE);
    assign bus.if_id_stall  = hold || (rst && cause == C_LOAD_USE);
    assign bus.id_ex_stall  = hold;
    assign bus.ex_mem_stall = hold;
    assign bus.mem_wb_flush = hold;
    assign bus.if_id_flush  = rst && cause == C_BRANCH;
    assign bus.id_ex_flush  = rst && (cause == C_BRANCH || cause == C_LOAD_USE);
    assign bus.div_busy     = rst && (state == ST_DIV || cause == C_DIV);
    assign bus.div_done     = rst && state == ST_DONE && !mem_wait;
`ifdef PIPE_HAZ_PERF_EN
    logic [31:0] perf_stall, perf_flush;
    // saturating counts of stall and ID/EX flush cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall <= '0;
            perf_flush <= '0;
        end else begin
            if (bus.pc_stall && !(&perf_stall)) perf_stall <= perf_stall + 1'b1;
            if (bus.id_ex_flush && !(&perf_flush)) perf_flush <= perf_flush + 1'b1;
        end
    end
    assign bus.perf_stall_cnt = perf_stall;
    assign bus.perf_flush_cnt = perf_flush;
`endif
endmodule
